// File: rtl/cla_seq_adder_if.sv
// ----------------------------------------------------------------------------
// cla_seq_adder_if
//   Bundles the request/result signals of cla_seq_adder.
//   master : requester side (drives start/sub/a/b, observes results)
//   slave  : adder side
//   Signals:
//     start, sub, a, b     request and operands
//     busy, done           status (done is a one-cycle pulse)
//     f, cf, of, zf        result and flags
//     gg, gp               per-group generate/propagate (only with CLA_GP_OUT_EN)
// ----------------------------------------------------------------------------
interface cla_seq_adder_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
);
    localparam int unsigned N = WIDTH / GROUP;

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             cf;
    logic             of;
    logic             zf;
`ifdef CLA_GP_OUT_EN
    logic [N-1:0]     gg;
    logic [N-1:0]     gp;
`endif

    modport master (
        output start, sub, a, b,
`ifdef CLA_GP_OUT_EN
        input  gg, gp,
`endif
        input  busy, done, f, cf, of, zf
    );

    modport slave (
        input  start, sub, a, b,
`ifdef CLA_GP_OUT_EN
        output gg, gp,
`endif
        output busy, done, f, cf, of, zf
    );
endinterface

// File: rtl/cla_seq_adder.sv
// ----------------------------------------------------------------------------
// cla_seq_adder
//   Multi-cycle add/subtract unit. Resolves one GROUP-bit slice per clock with
//   carry-lookahead logic, holding the inter-group carry in a register.
//   Subtraction is A + ~B + 1 (carry-in = sub), so cf = 1 means no borrow.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  cla_seq_adder_if.slave: start/sub/a/b in, busy/done/f/cf/of/zf out
//
//   Optional feature (macro CLA_GP_OUT_EN): adds per-slice group generate (gg)
//   and group propagate (gp) outputs on the interface, bit k registered on the
//   edge that processes slice k, cleared on reset and on start acceptance.
//
//   Timing: done is high in the cycle WIDTH/GROUP edges after the edge that
//   accepted start. Start is accepted in IDLE and in DONE (back-to-back).
// ----------------------------------------------------------------------------
module cla_seq_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
) (
    input logic             clk,
    input logic             rst,
    cla_seq_adder_if.slave  bus
);
    localparam int unsigned N  = WIDTH / GROUP;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cf_q, cf_d;
    logic             of_q, of_d;
    logic             zf_q, zf_d;
`ifdef CLA_GP_OUT_EN
    logic [N-1:0]     gg_q, gg_d;
    logic [N-1:0]     gp_q, gp_d;
`endif

    // Current slice datapath
    int unsigned      base;
    logic [GROUP-1:0] xs, ys, gs, ps, sum;
    logic [GROUP:0]   c;
    logic             grp_g, grp_p;
    logic [WIDTH-1:0] f_upd;

    always_comb begin
        base = int'(k_q) * GROUP;
        xs   = x_q[base +: GROUP];
        ys   = y_q[base +: GROUP];
        gs   = xs & ys;
        ps   = xs | ys;

        // Lookahead form: c[i+1] = OR_j (g_j & p_{j+1..i}) | (p_{0..i} & cin).
        // Every carry depends only on the slice terms and the carry register.
        c    = '0;
        c[0] = carry_q;
        for (int i = 0; i < int'(GROUP); i++) begin
            logic acc;
            logic term;
            term = carry_q;
            for (int j = 0; j <= i; j++) begin
                term = term & ps[j];
            end
            acc = term;
            for (int j = 0; j <= i; j++) begin
                logic t;
                t = gs[j];
                for (int m = j + 1; m <= i; m++) begin
                    t = t & ps[m];
                end
                acc = acc | t;
            end
            c[i+1] = acc;
        end

        for (int i = 0; i < int'(GROUP); i++) begin
            sum[i] = xs[i] ^ ys[i] ^ c[i];
        end

        // Group generate/propagate (independent of carry-in)
        grp_p = &ps;
        grp_g = 1'b0;
        for (int j = 0; j < int'(GROUP); j++) begin
            logic t;
            t = gs[j];
            for (int m = j + 1; m < int'(GROUP); m++) begin
                t = t & ps[m];
            end
            grp_g = grp_g | t;
        end

        f_upd = f_q;
        f_upd[base +: GROUP] = sum;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        carry_d = carry_q;
        k_d     = k_q;
        f_d     = f_q;
        cf_d    = cf_q;
        of_d    = of_q;
        zf_d    = zf_q;
`ifdef CLA_GP_OUT_EN
        gg_d    = gg_q;
        gp_d    = gp_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    x_d     = bus.a;
                    y_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    k_d     = '0;
                    state_d = StRun;
`ifdef CLA_GP_OUT_EN
                    gg_d    = '0;
                    gp_d    = '0;
`endif
                end
            end
            StRun: begin
                f_d     = f_upd;
                carry_d = c[GROUP];
                k_d     = k_q + 1'b1;
`ifdef CLA_GP_OUT_EN
                gg_d[k_q] = grp_g;
                gp_d[k_q] = grp_p;
`endif
                if (k_q == KLast) begin
                    state_d = StDone;
                    k_d     = '0;
                    cf_d    = c[GROUP];
                    // c[GROUP-1] of the top slice is the MSB carry-in
                    of_d    = c[GROUP] ^ c[GROUP-1];
                    zf_d    = (f_upd == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            f_q     <= '0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
`ifdef CLA_GP_OUT_EN
            gg_q    <= '0;
            gp_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            f_q     <= f_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
`ifdef CLA_GP_OUT_EN
            gg_q    <= gg_d;
            gp_q    <= gp_d;
`endif
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.f    = f_q;
    assign bus.cf   = cf_q;
    assign bus.of   = of_q;
    assign bus.zf   = zf_q;
`ifdef CLA_GP_OUT_EN
    assign bus.gg   = gg_q;
    assign bus.gp   = gp_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned GROUP = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cla_seq_adder_if #(.WIDTH(WIDTH), .GROUP(GROUP)) bus ();

    cla_seq_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Flags expected to be held from the previous completed operation
    logic prev_cf = 1'b0;
    logic prev_of = 1'b0;
    logic prev_zf = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request now; returns #1 after the accepting edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        check("done_after_accept", bus.done, 0);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] ef, input logic ecf,
                             input logic eof, input logic ezf);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                check({tag, "_cf_hold"}, bus.cf, prev_cf);
                check({tag, "_of_hold"}, bus.of, prev_of);
                check({tag, "_zf_hold"}, bus.zf, prev_zf);
            end
        end while (!bus.done && cyc < 20);
        check({tag, "_latency"}, cyc, 8);
        check({tag, "_f"},  bus.f,  ef);
        check({tag, "_cf"}, bus.cf, ecf);
        check({tag, "_of"}, bus.of, eof);
        check({tag, "_zf"}, bus.zf, ezf);
        check({tag, "_busy"}, bus.busy, 0);
        prev_cf = ecf;
        prev_of = eof;
        prev_zf = ezf;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_f",    bus.f,    0);
        check("rst_cf",   bus.cf,   0);
        check("rst_of",   bus.of,   0);
        check("rst_zf",   bus.zf,   0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Carry ripples through all groups to a zero result
        launch(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        wait_done("add_wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("hold_done", bus.done, 0);
        check("hold_f",    bus.f,    32'h0000_0000);
        check("hold_zf",   bus.zf,   1);

        // Signed overflow
        launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Subtract with borrow, then back-to-back subtract accepted in DONE
        launch(32'd5, 32'd7, 1'b1);
        wait_done("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        launch(32'd7, 32'd5, 1'b1);
        wait_done("sub_chain", 32'h0000_0002, 1'b1, 1'b0, 1'b0);

`ifdef CLA_GP_OUT_EN
        @(posedge clk);
        #1;
        launch(32'h0000_000F, 32'h0000_0001, 1'b0);
        wait_done("gp_add", 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        check("gp_gg", bus.gg, 8'h01);
        check("gp_gp", bus.gp, 8'h01);
        launch(32'h0, 32'h0, 1'b0);
        check("gp_gg_clear", bus.gg, 8'h00);
        wait_done("gp_zero", 32'h0, 1'b0, 1'b0, 1'b1);
        check("gp_gg_zero", bus.gg, 8'h00);
        check("gp_gp_zero", bus.gp, 8'h00);
`endif

        // Start pulsed mid-RUN must be ignored
        @(posedge clk);
        #1;
        launch(32'd1, 32'd2, 1'b0);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 3) begin
                bus.start = 1'b1;
                bus.a     = 32'd9;
                bus.b     = 32'd9;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_at = i;
                    check("ign_f", bus.f, 32'h0000_0003);
                end
            end
        end
        check("ign_busy_cycles", busy_cnt, 7);
        check("ign_done_count",  done_cnt, 1);
        check("ign_done_at",     done_at,  8);
        prev_cf = 1'b0;
        prev_of = 1'b0;
        prev_zf = 1'b0;

        // Reset on the 4th RUN edge aborts the operation
        launch(32'd2, 32'd2, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_f",    bus.f,    0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        prev_cf = 1'b0;
        prev_of = 1'b0;
        prev_zf = 1'b0;
        launch(32'd3, 32'd4, 1'b0);
        wait_done("after_abort", 32'd7, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
